// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bus bundle for the instruction fetch stage.
//   Memory side : imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in.
//   Core side   : inst_valid/instruction/pc out, inst_ready in.
//   master modport = fetch stage, slave modport = memory + core.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] pc;

  modport master (
    output imem_req, imem_addr, inst_valid, instruction, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, instruction, pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage in front of the RV32I core.
// Owns the fetch PC, issues single-outstanding word reads over a
// request/grant/response bus, buffers returned words with their PCs in a
// DEPTH-entry FIFO and presents them to the core with valid/ready.
// A redirect flushes the FIFO and discards any in-flight response.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   redirect          : load redirect_pc (bits [1:0] ignored) and flush
//   redirect_pc[31:0] : new fetch target
//   bus (master)      : imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata,
//                       inst_valid/inst_ready/instruction/pc
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  inst_fetch_if.master bus
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state;
  logic          req_q;
  logic          drop;
  logic [31:0]   fetch_pc;
  logic [31:0]   target_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          head_valid;
  logic          push;
  logic          pop;
  logic          slot_free;

  always_comb begin
    target_pc  = redirect_pc & 32'hFFFF_FFFC;
    head_valid = (count != '0);
    pop        = head_valid && bus.inst_ready && !redirect;
    push       = (state == S_WAIT) && bus.imem_rvalid && !drop && !redirect;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(push) - CW'(pop);
    // Outstanding is zero wherever this is consulted (IDLE, or WAIT as the
    // response lands), so the reservation rule reduces to the next count.
    slot_free = (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      // fetch_pc only advances on an accepted (pushed) response; dropped
      // responses and redirects never bump it.
      if (redirect)  fetch_pc <= target_pc;
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      case (state)
        S_IDLE: begin
          if (slot_free) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end
        S_REQ: begin
          // Redirect without grant just retargets the pending request.
          if (bus.imem_gnt) begin
            state <= S_WAIT;
            req_q <= 1'b0;
            drop  <= redirect;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            drop <= 1'b0;
            if (slot_free) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_IDLE;
              req_q <= 1'b0;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          req_q <= 1'b0;
          drop  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.inst_valid  = head_valid;
  assign bus.instruction = head_valid ? data_mem[rd_ptr] : NOP;
  assign bus.pc          = head_valid ? pc_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;

  // memory responder state
  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  logic        allow_overlap;
  logic        pending;
  int          cd;
  logic [31:0] pend_addr;
  int          n_grants;
  logic [31:0] last_gnt_addr;

  // reference model of the delivered stream
  logic [31:0] exp_pc;
  logic        hold_prev;
  logic [31:0] hold_addr;
  int          n_consumed;
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // One clock cycle. Entered at negedge+1 with inputs set for the cycle.
  // Scores the cycle just before the rising edge, then plays the memory
  // at the following negedge, returning at negedge+1.
  task automatic tick();
    #3;
    if (reset) begin
      exp_pc    = 32'h0;
      hold_prev = 1'b0;
    end else begin
      if (bus.inst_valid !== 1'b1) begin
        n_cmp++;
        if (bus.instruction !== NOP || bus.pc !== 32'h0) begin
          n_err++;
          $display("FAIL idle_head: instruction=%h pc=%h, want %h / 0", bus.instruction, bus.pc, NOP);
        end
      end
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
        n_cmp++;
        if (bus.pc !== exp_pc || bus.instruction !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL stream: pc=%h instr=%h, want pc=%h instr=%h", bus.pc, bus.instruction, exp_pc, mem_word(exp_pc));
        end
        last_pc    = bus.pc;
        last_instr = bus.instruction;
        n_consumed++;
        exp_pc     = exp_pc + 32'd4;
      end
      if (hold_prev && bus.imem_req === 1'b1) begin
        n_cmp++;
        if (bus.imem_addr !== hold_addr) begin
          n_err++;
          $display("FAIL addr_hold: imem_addr=%h, want %h", bus.imem_addr, hold_addr);
        end
      end
      hold_prev = (bus.imem_req === 1'b1) && (bus.imem_gnt !== 1'b1) && !redirect;
      hold_addr = bus.imem_addr;
    end

    @(negedge clock);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    if (pending) begin
      if (cd == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
        pending         = 1'b0;
      end else begin
        cd--;
      end
    end
    if (bus.imem_req === 1'b1) begin
      if (!allow_overlap) begin
        n_cmp++;
        if (pending) begin
          n_err++;
          $display("FAIL one_outstanding: imem_req=1 with response pending, want 0");
        end
      end
      if (!pending && $urandom_range(99, 0) < gnt_pct) begin
        bus.imem_gnt  = 1'b1;
        pending       = 1'b1;
        pend_addr     = bus.imem_addr;
        cd            = $urandom_range(lat_max, lat_min) - 1;
        n_grants++;
        last_gnt_addr = bus.imem_addr;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    int c0;
    bus.inst_ready = 1'b1;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    reset = 1'b1; redirect = 1'b0;
    repeat (4) tick();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
    n_cmp++; if (bus.instruction !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", bus.instruction, NOP); end
    n_cmp++; if (bus.pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus.pc); end
    reset = 1'b0;
    first = -1;
    c0 = n_consumed;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 1) begin
        n_cmp++;
        if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
      end
      if (first < 0 && bus.inst_valid === 1'b1) first = i;
    end
    n_cmp++; if (first != 3) begin n_err++; $display("FAIL first_valid_edge: got %0d want 3", first); end
    n_cmp++;
    if (n_consumed - c0 != 4 || last_pc !== 32'hC) begin
      n_err++; $display("FAIL stream_rate: consumed=%0d last_pc=%h, want 4 / 0000000c", n_consumed - c0, last_pc);
    end
  endtask

  task automatic test_stall();
    int g0;
    int c0;
    bus.inst_ready = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    g0 = n_grants;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.pc !== 32'h0) begin
        n_err++; $display("FAIL stall_hold: req=%b valid=%b pc=%h, want 0/1/0", bus.imem_req, bus.inst_valid, bus.pc);
      end
      tick();
    end
    n_cmp++; if (n_grants - g0 != 2) begin n_err++; $display("FAIL stall_buffered: grants=%0d want 2", n_grants - g0); end
    c0 = n_consumed;
    g0 = n_grants;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 40 && n_grants == g0; i++) tick();
    n_cmp++;
    if (n_grants == g0 || last_gnt_addr !== 32'h8) begin
      n_err++; $display("FAIL stall_resume_addr: got %h (grants %0d) want 00000008", last_gnt_addr, n_grants - g0);
    end
    for (int i = 0; i < 40 && n_consumed - c0 < 3; i++) tick();
    n_cmp++;
    if (last_pc !== 32'h8) begin n_err++; $display("FAIL stall_resume_pc: got %h want 00000008", last_pc); end
  endtask

  task automatic test_redirect_wait();
    int g0;
    int c0;
    bus.inst_ready = 1'b0;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    g0 = n_grants;
    for (int i = 0; i < 60 && !(n_grants - g0 >= 2 && pending && bus.imem_gnt === 1'b0); i++) tick();
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || !pending) begin
      n_err++; $display("FAIL rw_setup: valid=%b pending=%b, want 1/1", bus.inst_valid, pending);
    end
    redirect = 1'b1; redirect_pc = 32'h100; bus.inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL rw_flush: valid=%b req=%b, want 0/0", bus.inst_valid, bus.imem_req);
    end
    g0 = n_grants;
    c0 = n_consumed;
    for (int i = 0; i < 40 && n_grants == g0; i++) tick();
    n_cmp++;
    if (n_grants == g0 || last_gnt_addr !== 32'h100) begin
      n_err++; $display("FAIL rw_next_addr: got %h want 00000100", last_gnt_addr);
    end
    for (int i = 0; i < 40 && n_consumed == c0; i++) tick();
    n_cmp++;
    if (n_consumed == c0 || last_pc !== 32'h100) begin
      n_err++; $display("FAIL rw_next_pc: got %h want 00000100", last_pc);
    end
  endtask

  task automatic test_redirect_gnt();
    int g0;
    int c0;
    bus.inst_ready = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 40 && !(bus.imem_gnt === 1'b1 && bus.inst_valid === 1'b1); i++) tick();
    redirect = 1'b1; redirect_pc = 32'h203; bus.inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL rg_flush: valid=%b req=%b, want 0/0", bus.inst_valid, bus.imem_req);
    end
    g0 = n_grants;
    c0 = n_consumed;
    for (int i = 0; i < 40 && n_grants == g0; i++) tick();
    n_cmp++;
    if (n_grants == g0 || last_gnt_addr !== 32'h200) begin
      n_err++; $display("FAIL rg_next_addr: got %h want 00000200", last_gnt_addr);
    end
    for (int i = 0; i < 40 && n_consumed == c0; i++) tick();
    n_cmp++;
    if (n_consumed == c0 || last_pc !== 32'h200 || last_instr !== mem_word(32'h200)) begin
      n_err++; $display("FAIL rg_next_pc: got %h/%h want 00000200/%h", last_pc, last_instr, mem_word(32'h200));
    end
  endtask

  task automatic test_gnt_hold();
    int g0;
    int c0;
    bus.inst_ready = 1'b1;
    gnt_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) tick();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
        n_err++; $display("FAIL gh_hold: req=%b addr=%h, want 1/00000000", bus.imem_req, bus.imem_addr);
      end
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      n_err++; $display("FAIL gh_switch: req=%b addr=%h, want 1/00000040", bus.imem_req, bus.imem_addr);
    end
    tick();
    gnt_pct = 100;
    g0 = n_grants;
    c0 = n_consumed;
    for (int i = 0; i < 20 && n_grants == g0; i++) tick();
    n_cmp++;
    if (n_grants == g0 || last_gnt_addr !== 32'h40) begin
      n_err++; $display("FAIL gh_granted: got %h want 00000040", last_gnt_addr);
    end
    for (int i = 0; i < 40 && n_consumed == c0; i++) tick();
    n_cmp++;
    if (n_consumed == c0 || last_pc !== 32'h40) begin
      n_err++; $display("FAIL gh_pc: got %h want 00000040", last_pc);
    end
  endtask

  task automatic test_wrap();
    int c0;
    bus.inst_ready = 1'b1;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    tick();
    redirect = 1'b0;
    c0 = n_consumed;
    for (int i = 0; i < 60 && n_consumed - c0 < 3; i++) tick();
    n_cmp++;
    if (n_consumed - c0 < 3 || last_pc !== 32'h0 || last_instr !== mem_word(32'h0)) begin
      n_err++; $display("FAIL wrap: pc=%h instr=%h want 00000000/%h", last_pc, last_instr, mem_word(32'h0));
    end
  endtask

  task automatic test_random();
    int c0;
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    c0 = n_consumed;
    for (int i = 0; i < 1500; i++) begin
      bus.inst_ready = ($urandom_range(3, 0) != 0);
      redirect = ($urandom_range(29, 0) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    n_cmp++;
    if (n_consumed - c0 < 100) begin
      n_err++; $display("FAIL random_progress: consumed=%0d want >=100", n_consumed - c0);
    end
  endtask

  task automatic test_reset_mid();
    int g0;
    int c0;
    bus.inst_ready = 1'b1;
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    allow_overlap = 1'b1;
    do_reset();
    g0 = n_grants;
    for (int i = 0; i < 60 && !(n_grants - g0 >= 2 && pending && bus.imem_gnt === 1'b0); i++) tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0 ||
        bus.instruction !== NOP || bus.pc !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, want 0/0/0/%h/0",
               bus.imem_req, bus.imem_addr, bus.inst_valid, bus.instruction, bus.pc, NOP);
    end
    reset = 1'b0;
    c0 = n_consumed;
    for (int i = 0; i < 60 && n_consumed == c0; i++) tick();
    n_cmp++;
    if (n_consumed == c0 || last_pc !== 32'h0 || last_instr !== mem_word(32'h0)) begin
      n_err++; $display("FAIL mid_reset_stray: pc=%h instr=%h want 00000000/%h", last_pc, last_instr, mem_word(32'h0));
    end
    allow_overlap = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.inst_ready = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1; allow_overlap = 1'b0;
    pending = 1'b0; cd = 0; pend_addr = 32'h0; n_grants = 0; last_gnt_addr = 32'h0;
    exp_pc = 32'h0; hold_prev = 1'b0; hold_addr = 32'h0;
    n_consumed = 0; last_pc = 32'h0; last_instr = 32'h0;
    @(negedge clock);
    #1;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_gnt_hold();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage upstream of the single-cycle RV32I core.
- Owns the fetch PC and issues word reads to instruction memory over a request/grant/response bus with variable latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the core with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect  input  1  load redirect_pc and flush.
- redirect_pc  input  32  new fetch target; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  read request valid.
- imem_addr  output  32  word-aligned read address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid; at most one response per grant; arrives 1 or more cycles after the grant.
- imem_rdata  input  32  read data.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  core consumes the head.
- instruction  output  32  head instruction word; 32'h00000013 (NOP) when inst_valid=0.
- pc  output  32  address of the head instruction; 0 when inst_valid=0.

Behaviour:
- Reset (sync, high):
  - FSM=IDLE; fetch_pc=RESET_PC; FIFO empty; drop=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=32'h00000013, pc=0.
- Single outstanding request. A slot is reserved when a request is granted: issue only if fifo_count + outstanding < DEPTH.
- FSM:
  - IDLE -> REQ when a slot is free.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - imem_gnt=1 -> WAIT.
    - imem_gnt=0 -> hold REQ with address unchanged.
  - WAIT: imem_req=0.
    - On imem_rvalid: push {fetch_pc, imem_rdata}; fetch_pc += 4 (wraps modulo 2^32).
    - Then go to REQ if a slot is free after this cycle's push/pop, else IDLE.
- Latency: reset deasserted before edge E0 -> imem_req=1 after E0. With gnt in that cycle and rvalid in the next, inst_valid=1 after E2. Back-to-back fetch sustains 1 word per 2 cycles at minimum memory latency.
- FIFO:
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle keep the count unchanged, including when full.
  - No push is ever attempted while full; the reservation rule guarantees this.
- Redirect (highest priority, any state):
  - FIFO flushed; inst_valid=0 the next cycle. A same-cycle pop is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - REQ, no gnt: the request is withdrawn; the next cycle presents the new address (REQ).
  - REQ with gnt: -> WAIT with drop=1.
  - WAIT, no rvalid: stay WAIT; drop=1.
  - WAIT with rvalid: response discarded; -> REQ at the new pc; drop=0.
- drop=1 handling:
  - The next rvalid is discarded (no push, fetch_pc unchanged); drop clears; -> REQ/IDLE per slot rule.
  - A further redirect while drop=1 only updates fetch_pc.
- Reset mid-transaction: state is cleared. A late rvalid arriving in IDLE/REQ is ignored (response outside WAIT is ignored).

Test Plan:
- Reset then gnt=1 always, rvalid 1 cycle after grant, ready=1 -> instructions with pc 0x0, 0x4, 0x8, 0xC in order; first inst_valid 3 edges after reset release; imem_addr never changes while req=1 and gnt=0.
- ready=0, DEPTH=2 -> exactly 2 words buffered, imem_req stays 0; raise ready -> pc 0x0 then 0x4 popped, fetching resumes at 0x8.
- Redirect to 0x100 while in WAIT with rvalid 3 cycles later -> late word discarded, FIFO empty, next imem_addr=0x100, next delivered pc=0x100.
- Redirect to 0x203 same cycle as gnt and as inst_ready pop -> FIFO flushed, in-flight response dropped, next fetch and delivered pc=0x200.
- gnt held low 5 cycles, redirect to 0x40 in cycle 3 -> imem_addr switches to 0x40 next cycle; the old address is never granted.
- fetch_pc=0xFFFFFFFC -> next delivered pc wraps to 0x00000000; reset asserted during WAIT -> all outputs return to reset values, stray rvalid ignored.
